display_tempo: RTL
==================

// Module: display_tempo
// PURPOSE
//  Display back end for the stopwatch tick counter. Takes the binary decisecond
//  count (0..10000) and converts it to 4 BCD digits with a sequential
//  double-dabble converter. Drives a 4-digit multiplexed 7-segment display in
//  the format SSS.d. Sits between the counter's 14-bit count output and the
//  board's segment and anode pins.
// PARAMETERS
//  REFRESH_DIV  50000  clk cycles per digit slot (1 kHz per digit at 50 MHz)
//  NBITS        14     width of the binary input (fixed; 14 shift steps)
// PORTS
//  clk       in   1   system clock, 50 MHz
//  rst       in   1   reset, asynchronous, active-high
//  number    in   14  binary decisecond count from the counter
//  seg       out  7   segments {g,f,e,d,c,b,a}, active-low
//  dp        out  1   decimal point, active-low
//  an        out  4   digit anodes, active-low; an[0] is the rightmost digit (d)
//  bcd       out  16  latched BCD {thousands,hundreds,tens,units}
//  bcdValid  out  1   one-cycle pulse when bcd is updated
// BEHAVIOUR
//  Reset values: state IDLE, bcd=0, lastSampled=0, bcdValid=0, refCnt=0,
//   idx=0, an=4'b1110, seg=7'b1000000 ("0"), dp=1.
//  Converter states:
//   IDLE: when number != lastSampled, capture on that edge (edge 0).
//    - lastSampled <= number.
//    - Load value = (number>9999) ? 9999 : number.
//    - Clear the BCD accumulator and shift count.
//    - Go to SHIFT.
//   SHIFT: one step per edge, edges 1..14. Add 3 to each accumulator nibble >=5,
//    then shift {acc,bin} left by 1. After the 14th step go to DONE.
//   DONE: on edge 15, bcd <= acc and bcdValid=1 for that cycle only; go to IDLE.
//  Latency: 15 cycles from capture to bcd update. Next capture is possible on
//   edge 16.
//  Changes on number during SHIFT/DONE are ignored. IDLE picks them up
//   afterwards via the lastSampled compare, so only the latest value is shown.
//  number=10000 (wrap tick) is clamped: it displays 999.9 and does not roll
//   to 000.0.
//  Reset mid-conversion aborts the conversion. No bcdValid is produced; bcd
//   returns to 0. After release, a nonzero number reconverts because
//   lastSampled=0.
//  Scanner: refCnt counts 0..REFRESH_DIV-1. At terminal count, refCnt <= 0 and
//   idx <= idx+1 mod 4 (2-bit counter that wraps).
//   - an = ~(4'b0001 << idx); exactly one anode is low at all times.
//   - seg = 7-segment pattern of nibble idx of bcd. Patterns 0..9 are standard
//     active-low; a nibble >9 gives blank (7'b1111111).
//   - dp=0 only when idx==1 (point between seconds and deciseconds).
//   - Leading-zero blanking: digit 3 is blank when bcd[15:12]==0. Digit 2 is
//     blank when bcd[15:8]==0. Digits 1 and 0 are always shown.
//  seg, an and dp are combinational from the registered idx and bcd, with no
//   extra latency. A bcd update is visible on the next scan slot of each digit.
// STRUCTURE
//  Package tempo_pkg:
//   - Converter state encoding (IDLE/SHIFT/DONE).
//   - N_DIGITS=4, SEG_BLANK=7'b1111111, MAX_DS=9999.
//   - Function seg7(nibble) returning the active-low pattern.
//  Sub-module bin2bcd_seq: the converter FSM. It owns clk, rst, number, bcd,
//   bcdValid and the lastSampled register.
//  The top holds the refresh counter, idx, blanking and the segment mux.
// TESTING
//  1. Assert rst for 3 cycles, then release with number=0
//     -> an=1110, seg=1000000, dp=1, bcd=0; no bcdValid for 100 cycles.
//  2. Set number=1234 and hold it
//     -> bcdValid pulses exactly 15 cycles after capture; bcd=16'h1234.
//     With REFRESH_DIV=4, the scan shows "123.4".
//  3. Set number=10000
//     -> bcd=16'h9999. Then set number=0 -> bcd=16'h0000 after 15 cycles.
//  4. Set number=5
//     -> bcd=16'h0005. Slots idx3 and idx2 have seg=1111111. Slot idx1 shows
//     "0" with dp=0. Slot idx0 shows "5".
//  5. Set REFRESH_DIV=4
//     -> an follows 1110,1101,1011,0111,1110, each held exactly 4 cycles.
//     Never zero or two anodes low.
//  6. Set number=1234 and assert rst at edge 7 of the conversion
//     -> no bcdValid; bcd=0. After release, reconversion gives 16'h1234.
//     Changing number to 42 during SHIFT -> the first result is 16'h1234, then
//     16'h0042.

Source files
------------

// File: rtl/display_tempo_pkg.sv
// Shared types, constants and the 7-segment decoder for the stopwatch display back end.
package tempo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } conv_state_e;

  localparam int          N_DIGITS  = 4;
  localparam int          NBITS     = 14;
  localparam logic [6:0]  SEG_BLANK = 7'b1111111;
  localparam logic [13:0] MAX_DS    = 14'd9999;

  // Active-low pattern {g,f,e,d,c,b,a}; anything outside 0..9 is dark.
  function automatic logic [6:0] seg7(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'd0:    pat = 7'b1000000;
      4'd1:    pat = 7'b1111001;
      4'd2:    pat = 7'b0100100;
      4'd3:    pat = 7'b0110000;
      4'd4:    pat = 7'b0011001;
      4'd5:    pat = 7'b0010010;
      4'd6:    pat = 7'b0000010;
      4'd7:    pat = 7'b1111000;
      4'd8:    pat = 7'b0000000;
      4'd9:    pat = 7'b0010000;
      default: pat = SEG_BLANK;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/display_tempo_if.sv
// Bundle between the counter/board side and the display back end.
interface display_tempo_if;
  logic [13:0] number;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic [15:0] bcd;
  logic        bcdValid;

  modport master (output number, input seg, dp, an, bcd, bcdValid);
  modport slave  (input number, output seg, dp, an, bcd, bcdValid);
endinterface

// File: rtl/display_tempo_bin2bcd_seq.sv
// Sequential double-dabble converter: one shift per clock, 15 cycles from
// capture to a latched BCD result. Only reconverts when the input changes.
module bin2bcd_seq
  import tempo_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [13:0] number,
  output logic [15:0] bcd,
  output logic        bcd_valid
);

  conv_state_e state_q, state_d;
  logic [13:0] last_q, last_d;
  logic [13:0] bin_q, bin_d;
  logic [15:0] acc_q, acc_d;
  logic [3:0]  step_q, step_d;
  logic [15:0] bcd_q, bcd_d;
  logic        valid_q, valid_d;
  logic [15:0] adj;

  // State and datapath registers; reset also aborts any conversion in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      last_q  <= '0;
      bin_q   <= '0;
      acc_q   <= '0;
      step_q  <= '0;
      bcd_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      bin_q   <= bin_d;
      acc_q   <= acc_d;
      step_q  <= step_d;
      bcd_q   <= bcd_d;
      valid_q <= valid_d;
    end
  end

  // Next-state: capture on change, 14 add-3/shift steps, then publish.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    bin_d   = bin_q;
    acc_d   = acc_q;
    step_d  = step_q;
    bcd_d   = bcd_q;
    valid_d = 1'b0;

    adj = acc_q;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (adj[i*4 +: 4] >= 4'd5) adj[i*4 +: 4] = adj[i*4 +: 4] + 4'd3;
    end

    case (state_q)
      ST_IDLE: begin
        if (number != last_q) begin
          last_d  = number;
          // The wrap tick (10000) must not show as 000.0.
          bin_d   = (number > MAX_DS) ? MAX_DS : number;
          acc_d   = '0;
          step_d  = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        {acc_d, bin_d} = {adj[14:0], bin_q, 1'b0};
        step_d = step_q + 4'd1;
        if (step_q == 4'(NBITS - 1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        bcd_d   = acc_q;
        valid_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bcd       = bcd_q;
  assign bcd_valid = valid_q;

endmodule

// File: rtl/display_tempo.sv
// Stopwatch display back end: binary deciseconds -> BCD -> multiplexed
// 4-digit 7-segment display showing SSS.d with leading-zero blanking.
module display_tempo
  import tempo_pkg::*;
#(
  parameter int REFRESH_DIV = 50000
) (
  input  logic            clk,
  input  logic            rst,
  display_tempo_if.slave  bus
);

  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [N_DIGITS*4-1:0] bcd_w;
  logic                  valid_w;
  logic [RW-1:0]         ref_cnt_q, ref_cnt_d;
  logic [1:0]            idx_q, idx_d;
  logic [3:0]            nib;
  logic                  blank;

  bin2bcd_seq u_conv (
    .clk       (clk),
    .rst       (rst),
    .number    (bus.number),
    .bcd       (bcd_w),
    .bcd_valid (valid_w)
  );

  assign bus.bcd      = bcd_w;
  assign bus.bcdValid = valid_w;

  // Scan timing registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_cnt_q <= '0;
      idx_q     <= '0;
    end else begin
      ref_cnt_q <= ref_cnt_d;
      idx_q     <= idx_d;
    end
  end

  // Refresh divider; the digit index advances and wraps at terminal count.
  always_comb begin
    ref_cnt_d = ref_cnt_q + RW'(1);
    idx_d     = idx_q;
    if (ref_cnt_q == RW'(REFRESH_DIV - 1)) begin
      ref_cnt_d = '0;
      idx_d     = idx_q + 2'd1;
    end
  end

  // Digit mux: pick the nibble for the active slot, blank leading zeros.
  always_comb begin
    case (idx_q)
      2'd0:    nib = bcd_w[3:0];
      2'd1:    nib = bcd_w[7:4];
      2'd2:    nib = bcd_w[11:8];
      default: nib = bcd_w[15:12];
    endcase
    blank = ((idx_q == 2'd3) && (bcd_w[15:12] == 4'd0)) ||
            ((idx_q == 2'd2) && (bcd_w[15:8] == 8'd0));
    bus.seg = blank ? SEG_BLANK : seg7(nib);
    bus.an  = ~(4'b0001 << idx_q);
    bus.dp  = (idx_q != 2'd1);
  end

endmodule
